fan_ramp_scheduler: RTL
=======================

Name: fan_ramp_scheduler

Overview:
Sequences duty updates for the six slipstream fans. It sits between the target-percent datapath (wind × direction multiplier, clamped 0–100) and the six percent_pwm drivers. Fans are serviced round-robin, one fan per scheduler tick. Each serviced fan's duty moves toward its target at a bounded slew rate. A stalled fan (duty 0) starting up gets a timed kick-start, and only one fan may kick-start at a time, which limits inrush current.

Parameters:
CLK_DIV, 50000, i_clk cycles per scheduler tick (≥2)
STEP, 5, max duty change (percent) per service visit (1–100)
KICK_PERCENT, 80, duty applied during kick-start (1–100)
START_HOLD, 25, ticks a kick-start is held (≥1)

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset; asynchronous, active-high
i_enable  in  1  1 = run scheduler; 0 = all fans off
i_target_valid  in  1  target vector valid
i_targets  in  42  six 7-bit targets; fan1 = [6:0] … fan6 = [41:35]
o_target_ready  out  1  target vector accepted when valid && ready
o_fan_1..o_fan_6  out  7 each  duty percent to percent_pwm i_pwm_period
o_active_fan  out  3  index (0–5) of the fan serviced at the next tick
o_busy  out  1  1 if any duty ≠ its target, or in KICK

Behaviour:
- Reset (async, immediate):
  - all o_fan_* = 0, all target regs = 0, prescaler = 0, index = 0, state IDLE.
  - o_target_ready = 1, o_busy = 0.
- Target capture: on an edge with i_target_valid && o_target_ready, each 7-bit field is latched. Any field >100 is stored as 100. Capture is allowed in every state except KICK.
- o_target_ready is combinational: 0 only in state KICK.
- Prescaler:
  - Counts 0..CLK_DIV-1 in RUN/KICK and wraps.
  - "Tick" = an edge where prescaler == CLK_DIV-1.
  - Held at 0 in IDLE.
- States:
  - IDLE: duties 0. Next edge with i_enable=1 goes to RUN, prescaler starts at 0. The first tick therefore occurs CLK_DIV cycles after entering RUN.
  - RUN, on a tick, for fan = index, with d = duty and t = stored target:
    - d==0 and t>0: d := KICK_PERCENT, hold counter := START_HOLD-1, go to KICK. Index does not advance.
    - else if d<t: d := min(d+STEP, t).
    - else if d>t: d := max(d-STEP, t), computed without underflow (d<STEP → t).
    - index := index==5 ? 0 : index+1.
  - KICK, on each tick:
    - While hold counter > 0: decrement it. No fan updated.
    - When it is 0: d := (t ≤ KICK_PERCENT) ? t : KICK_PERCENT, advance index, go to RUN.
- Updates take effect on the tick edge; outputs are registered and visible the same cycle as the new state.
- Simultaneous target capture and tick on the same edge: the update uses the previously stored target. The new target applies from the next visit.
- i_enable=0 in RUN or KICK (including mid-kick): next edge forces all duties 0, index 0, prescaler 0, state IDLE. Stored targets are retained.
- Target changed to 0 for a fan in KICK: the kick completes and d := 0 (since t ≤ KICK_PERCENT).
- Only the serviced fan's duty changes on any tick. All other duties hold.
- All arithmetic is 8-bit unsigned internally; results are always within 0–100.

Test Plan:
Common setup: CLK_DIV=4, STEP=5, KICK_PERCENT=80, START_HOLD=2.
- Reset: assert i_rst asynchronously mid-RUN with o_fan_1=40 -> all o_fan_* = 0 before the next clock edge; o_target_ready=1; o_busy=0.
- Kick-start: targets {fan1=50, others 0}, enable -> on the 1st tick o_fan_1=80 and o_target_ready=0. On the 3rd tick o_fan_1=50, o_target_ready=1, o_active_fan=1.
- Ramp up: fan2 duty 20 with target raised to 33 -> successive fan2 visits (every 6 ticks = 24 cycles) give 25, 30, 33, then hold; o_busy drops after 33.
- Clamp + ramp down: capture fan3 target 120 -> stored as 100. Later set target 0 with duty 12 -> visits give 7, 2, 0.
- Disable mid-kick: drop i_enable during the fan1 kick (o_fan_1=80) -> next edge all duties 0, state IDLE, o_target_ready=1. Re-enable -> the kick restarts on the first tick.
- Collision: assert i_target_valid on the same edge as a fan4 tick (duty 10, old target 10, new target 60) -> fan4 stays 10 on that tick and reaches 15 on its next visit.

Source files
------------

// File: rtl/fan_ramp_scheduler_if.sv
// Control/target/duty bundle between the target datapath, the scheduler and the six PWM drivers.
// Targets use a valid/ready handshake; duties and status are plain registered levels.
interface fan_ramp_scheduler_if;
   logic        i_enable;
   logic        i_target_valid;
   logic [41:0] i_targets;
   logic        o_target_ready;
   logic [6:0]  o_fan_1;
   logic [6:0]  o_fan_2;
   logic [6:0]  o_fan_3;
   logic [6:0]  o_fan_4;
   logic [6:0]  o_fan_5;
   logic [6:0]  o_fan_6;
   logic [2:0]  o_active_fan;
   logic        o_busy;

   modport master (
      output i_enable, i_target_valid, i_targets,
      input  o_target_ready, o_fan_1, o_fan_2, o_fan_3, o_fan_4, o_fan_5, o_fan_6,
             o_active_fan, o_busy
   );

   modport slave (
      input  i_enable, i_target_valid, i_targets,
      output o_target_ready, o_fan_1, o_fan_2, o_fan_3, o_fan_4, o_fan_5, o_fan_6,
             o_active_fan, o_busy
   );
endinterface

// File: rtl/fan_ramp_scheduler.sv
// Round-robin slew-limited duty sequencer for six fans, one fan per CLK_DIV-cycle tick, one kick-start at a time.
// Duties are registered and change on the tick edge; targets are refused (ready low) only while a kick is held.
module fan_ramp_scheduler #(
   parameter int CLK_DIV      = 50000,
   parameter int STEP         = 5,
   parameter int KICK_PERCENT = 80,
   parameter int START_HOLD   = 25
) (
   input logic             i_clk,
   input logic             i_rst,
   fan_ramp_scheduler_if.slave bus
);
   localparam int PW = $clog2(CLK_DIV);
   localparam int HW = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_KICK = 2'd2;

   localparam logic [7:0]    STEP_8    = 8'(STEP);
   localparam logic [7:0]    KICK_8    = 8'(KICK_PERCENT);
   localparam logic [6:0]    KICK_7    = 7'(KICK_PERCENT);
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
   localparam logic [HW-1:0] HOLD_INIT = HW'(START_HOLD - 1);

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [2:0]    idx_q, idx_d, idx_next;
   logic [HW-1:0] hold_q, hold_d;
   logic [6:0]    duty_q [6];
   logic [6:0]    duty_d [6];
   logic [6:0]    tgt_q  [6];
   logic [6:0]    tgt_d  [6];
   logic          tick;
   logic          ready;
   logic          capture;
   logic          busy;

   function automatic logic [6:0] clamp100(input logic [6:0] v);
      return (v > 7'd100) ? 7'd100 : v;
   endfunction

   // One bounded step toward the target; the down path never wraps below zero.
   function automatic logic [6:0] slew(input logic [6:0] d, input logic [6:0] t);
      logic [7:0] d8;
      logic [7:0] t8;
      logic [7:0] r;
      d8 = {1'b0, d};
      t8 = {1'b0, t};
      if (d8 < t8) begin
         r = ((d8 + STEP_8) > t8) ? t8 : (d8 + STEP_8);
      end else if (d8 > t8) begin
         r = ((d8 < STEP_8) || ((d8 - STEP_8) < t8)) ? t8 : (d8 - STEP_8);
      end else begin
         r = d8;
      end
      return 7'(r);
   endfunction

   function automatic logic [6:0] kick_exit(input logic [6:0] t);
      return ({1'b0, t} <= KICK_8) ? t : KICK_7;
   endfunction

   assign ready    = (state_q != ST_KICK);
   assign capture  = bus.i_target_valid && ready;
   assign tick     = (state_q != ST_IDLE) && (presc_q == PRESC_MAX);
   assign idx_next = (idx_q == 3'd5) ? 3'd0 : (idx_q + 3'd1);

   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      idx_d   = idx_q;
      hold_d  = hold_q;
      for (int i = 0; i < 6; i++) begin
         duty_d[i] = duty_q[i];
         tgt_d[i]  = capture ? clamp100(bus.i_targets[i*7 +: 7]) : tgt_q[i];
      end

      if (state_q == ST_IDLE) begin
         presc_d = '0;
         for (int i = 0; i < 6; i++) duty_d[i] = '0;
         if (bus.i_enable) state_d = ST_RUN;
      end else if (!bus.i_enable) begin
         state_d = ST_IDLE;
         presc_d = '0;
         idx_d   = '0;
         hold_d  = '0;
         for (int i = 0; i < 6; i++) duty_d[i] = '0;
      end else begin
         presc_d = tick ? '0 : (presc_q + 1'b1);
         // Updates read tgt_q, so a target captured on a tick edge waits for the next visit.
         if (tick) begin
            if (state_q == ST_KICK) begin
               if (hold_q != '0) begin
                  hold_d = hold_q - 1'b1;
               end else begin
                  duty_d[idx_q] = kick_exit(tgt_q[idx_q]);
                  idx_d         = idx_next;
                  state_d       = ST_RUN;
               end
            end else if ((duty_q[idx_q] == 7'd0) && (tgt_q[idx_q] != 7'd0)) begin
               duty_d[idx_q] = KICK_7;
               hold_d        = HOLD_INIT;
               state_d       = ST_KICK;
            end else begin
               duty_d[idx_q] = slew(duty_q[idx_q], tgt_q[idx_q]);
               idx_d         = idx_next;
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= ST_IDLE;
         presc_q <= '0;
         idx_q   <= '0;
         hold_q  <= '0;
         for (int i = 0; i < 6; i++) begin
            duty_q[i] <= '0;
            tgt_q[i]  <= '0;
         end
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         idx_q   <= idx_d;
         hold_q  <= hold_d;
         for (int i = 0; i < 6; i++) begin
            duty_q[i] <= duty_d[i];
            tgt_q[i]  <= tgt_d[i];
         end
      end
   end

   always_comb begin
      busy = (state_q == ST_KICK);
      for (int i = 0; i < 6; i++) begin
         if (duty_q[i] != tgt_q[i]) busy = 1'b1;
      end
   end

   assign bus.o_target_ready = ready;
   assign bus.o_fan_1        = duty_q[0];
   assign bus.o_fan_2        = duty_q[1];
   assign bus.o_fan_3        = duty_q[2];
   assign bus.o_fan_4        = duty_q[3];
   assign bus.o_fan_5        = duty_q[4];
   assign bus.o_fan_6        = duty_q[5];
   assign bus.o_active_fan   = idx_q;
   assign bus.o_busy         = busy;
endmodule
